// File: rtl/exe_seq_pkg.sv
// rtl/exe_seq_pkg.sv - shared op-class, state and captured-op types for the execute sequencer
package exe_seq_pkg;

  typedef enum logic [1:0] {
    OP_ALU    = 2'b00,
    OP_BRANCH = 2'b01,
    OP_MULTI  = 2'b10,
    OP_NOP    = 2'b11
  } op_class_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_MULTI,
    S_BRCHK
  } state_e;

  typedef struct packed {
    op_class_e  cls;
    logic [3:0] alu_op;
    logic       use_imm;
    logic       br_ne;
  } op_t;

endpackage

// File: rtl/seq_counter.sv
// rtl/seq_counter.sv - loadable down-counter with zero flag for multi-cycle op occupancy
module seq_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/exe_sequencer.sv
// rtl/exe_sequencer.sv - execute-stage sequencer: op capture, multi-cycle hold, branch resolve and flush
module exe_sequencer
  import exe_seq_pkg::*;
#(
  parameter int MUL_LAT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  op_class,
  input  logic [3:0]  alu_op,
  input  logic        use_imm,
  input  logic        br_ne,
  input  logic        zero_q,
  input  logic        out_ready,
  output logic        regEn,
  output logic        muxSel,
  output logic [3:0]  aluControl,
  output logic        flush,
  output logic        busy,
  output logic [15:0] stall_cnt
);

  localparam int CNT_W = $clog2(MUL_LAT) + 1;

  state_e      state_q, state_d;
  op_t         op_q, op_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic        cnt_load, cnt_dec, cnt_zero, xfer;

  // Outputs decode only from registered state/op, so reset clears them without a clock.
  always_comb begin
    in_ready   = 1'b0;
    regEn      = 1'b0;
    flush      = 1'b0;
    muxSel     = 1'b0;
    aluControl = 4'd0;
    case (state_q)
      S_IDLE:  in_ready = 1'b1;
      S_EXEC: begin
        regEn      = out_ready;
        in_ready   = out_ready && (op_q.cls != OP_BRANCH);
        muxSel     = op_q.use_imm;
        aluControl = op_q.alu_op;
      end
      S_MULTI: begin
        muxSel     = op_q.use_imm;
        aluControl = op_q.alu_op;
      end
      S_BRCHK: flush = op_q.br_ne ? ~zero_q : zero_q;
      default: in_ready = 1'b0;
    endcase
    busy      = (state_q != S_IDLE);
    stall_cnt = stall_cnt_q;
  end

  always_comb begin
    xfer        = in_valid && in_ready;
    state_d     = state_q;
    op_d        = op_q;
    cnt_load    = 1'b0;
    cnt_dec     = 1'b0;
    stall_cnt_d = stall_cnt_q;
    case (state_q)
      S_EXEC: begin
        if (out_ready) state_d = (op_q.cls == OP_BRANCH) ? S_BRCHK : S_IDLE;
      end
      S_MULTI: begin
        cnt_dec = 1'b1;
        if (cnt_zero) state_d = S_EXEC;
      end
      S_BRCHK: state_d = S_IDLE;
      default: state_d = state_q;
    endcase
    // A transfer can only occur from IDLE or a retiring non-branch EXEC, so it overrides.
    if (xfer) begin
      op_d = '{cls: op_class_e'(op_class), alu_op: alu_op, use_imm: use_imm, br_ne: br_ne};
      case (op_class_e'(op_class))
        OP_ALU, OP_BRANCH: state_d = S_EXEC;
        OP_MULTI: begin
          state_d  = S_MULTI;
          cnt_load = 1'b1;
        end
        default: state_d = S_IDLE;
      endcase
    end
    if (in_valid && !in_ready && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      op_q        <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  seq_counter #(
    .WIDTH(CNT_W)
  ) u_mul_cnt (
    .clk     (clk),
    .rst     (rst),
    .load    (cnt_load),
    .load_val(CNT_W'(MUL_LAT - 2)),
    .dec     (cnt_dec),
    .zero    (cnt_zero)
  );

endmodule

// File: tb/tb_exe_sequencer.sv
// tb/tb_exe_sequencer.sv - vector table plus scoreboard bench for exe_sequencer
module tb_exe_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [1:0]  op_class;
  logic [3:0]  alu_op;
  logic        use_imm, br_ne, zero_q, out_ready;
  logic        regEn, muxSel, flush, busy;
  logic [3:0]  aluControl;
  logic [15:0] stall_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [3:0] alu;
    logic       imm;
  } sb_t;
  sb_t sb_q[$];
  sb_t sb_e;

  typedef struct {
    logic [1:0] cls;
    logic [3:0] alu;
    logic       imm;
    logic       bne;
    logic       zq;
    int         exp_busy;
    int         exp_reg;
    int         exp_flush;
  } vec_t;
  vec_t vecs[8];

  always #5 clk = ~clk;

  exe_sequencer #(.MUL_LAT(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_class  (op_class),
    .alu_op    (alu_op),
    .use_imm   (use_imm),
    .br_ne     (br_ne),
    .zero_q    (zero_q),
    .out_ready (out_ready),
    .regEn     (regEn),
    .muxSel    (muxSel),
    .aluControl(aluControl),
    .flush     (flush),
    .busy      (busy),
    .stall_cnt (stall_cnt)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push(input logic [3:0] a, input logic i);
    sb_t e;
    e.alu = a;
    e.imm = i;
    sb_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (regEn && flush) begin
        n_cmp++;
        n_bad++;
        $display("FAIL regen_flush_overlap: got both high expected exclusive");
      end
      if (regEn) begin
        if (sb_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL sb_unexpected_regen: got regEn=1 expected no pending op");
        end else begin
          sb_e = sb_q.pop_front();
          chk("sb_aluControl", int'(aluControl), int'(sb_e.alu));
          chk("sb_muxSel", int'(muxSel), int'(sb_e.imm));
        end
      end
    end
  end

  task automatic run_vec(input vec_t v, input int idx);
    int nb, nr, nf;
    nb = 0; nr = 0; nf = 0;
    op_class = v.cls; alu_op = v.alu; use_imm = v.imm; br_ne = v.bne; zero_q = v.zq;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    @(negedge clk);
    chk($sformatf("vec%0d_in_ready", idx), int'(in_ready), 1);
    if (v.cls != 2'b11) push(v.alu, v.imm);
    step();
    in_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      nb += int'(busy);
      nr += int'(regEn);
      nf += int'(flush);
    end
    chk($sformatf("vec%0d_busy_cycles", idx), nb, v.exp_busy);
    chk($sformatf("vec%0d_regen_cycles", idx), nr, v.exp_reg);
    chk($sformatf("vec%0d_flush_cycles", idx), nf, v.exp_flush);
    step();
  endtask

  initial begin
    int s0;
    vecs[0] = '{2'b00, 4'd3,  1'b1, 1'b0, 1'b0, 1, 1, 0};
    vecs[1] = '{2'b00, 4'd12, 1'b0, 1'b0, 1'b0, 1, 1, 0};
    vecs[2] = '{2'b01, 4'd6,  1'b0, 1'b0, 1'b1, 2, 1, 1};
    vecs[3] = '{2'b01, 4'd6,  1'b0, 1'b1, 1'b1, 2, 1, 0};
    vecs[4] = '{2'b01, 4'd6,  1'b1, 1'b0, 1'b0, 2, 1, 0};
    vecs[5] = '{2'b01, 4'd6,  1'b1, 1'b1, 1'b0, 2, 1, 1};
    vecs[6] = '{2'b10, 4'd6,  1'b1, 1'b0, 1'b0, 4, 1, 0};
    vecs[7] = '{2'b11, 4'd0,  1'b0, 1'b0, 1'b0, 0, 0, 0};

    rst = 1'b0; in_valid = 1'b0; op_class = 2'b00; alu_op = 4'd0;
    use_imm = 1'b0; br_ne = 1'b0; zero_q = 1'b0; out_ready = 1'b1;
    #2;
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_regEn", int'(regEn), 0);
    chk("rst_aluControl", int'(aluControl), 0);
    chk("rst_stall_cnt", int'(stall_cnt), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    step();

    for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

    // Back-to-back ALU ops, one per cycle
    op_class = 2'b00; out_ready = 1'b1; in_valid = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      alu_op = 4'(i);
      use_imm = i[0];
      push(alu_op, use_imm);
      @(negedge clk);
      chk("b2b_in_ready", int'(in_ready), 1);
      if (i > 1) begin
        chk("b2b_regEn", int'(regEn), 1);
        chk("b2b_aluControl", int'(aluControl), i - 1);
      end
      step();
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("b2b_last_regEn", int'(regEn), 1);
    chk("b2b_last_aluControl", int'(aluControl), 3);
    chk("b2b_last_in_ready", int'(in_ready), 1);
    step();
    @(negedge clk);
    chk("b2b_idle", int'(busy), 0);
    step();

    // MULTI with in_valid held: four cycles of occupancy, three stall cycles
    op_class = 2'b10; alu_op = 4'd6; use_imm = 1'b0; in_valid = 1'b1;
    push(4'd6, 1'b0);
    @(negedge clk);
    s0 = int'(stall_cnt);
    chk("mul_accept", int'(in_ready), 1);
    step();
    op_class = 2'b00; alu_op = 4'd5; use_imm = 1'b1;
    push(4'd5, 1'b1);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk($sformatf("mul_c%0d_in_ready", k), int'(in_ready), (k == 4) ? 1 : 0);
      chk($sformatf("mul_c%0d_regEn", k), int'(regEn), (k == 4) ? 1 : 0);
      chk($sformatf("mul_c%0d_busy", k), int'(busy), 1);
      chk($sformatf("mul_c%0d_aluControl", k), int'(aluControl), 6);
      step();
      if (k == 4) in_valid = 1'b0;
    end
    @(negedge clk);
    chk("mul_next_regEn", int'(regEn), 1);
    chk("mul_next_aluControl", int'(aluControl), 5);
    chk("mul_stall_delta", int'(stall_cnt) - s0, 3);
    step();

    // EXEC held by out_ready low, with a NOP waiting
    op_class = 2'b00; alu_op = 4'd9; use_imm = 1'b1; in_valid = 1'b1;
    push(4'd9, 1'b1);
    @(negedge clk);
    s0 = int'(stall_cnt);
    step();
    op_class = 2'b11; out_ready = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      chk("hold_regEn", int'(regEn), 0);
      chk("hold_aluControl", int'(aluControl), 9);
      chk("hold_in_ready", int'(in_ready), 0);
      step();
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("hold_release_regEn", int'(regEn), 1);
    chk("hold_release_aluControl", int'(aluControl), 9);
    chk("hold_stall_delta", int'(stall_cnt) - s0, 5);
    step();
    in_valid = 1'b0;
    @(negedge clk);
    chk("hold_after_regEn", int'(regEn), 0);
    chk("hold_after_busy", int'(busy), 0);
    step();

    // Reset in the second MULTI cycle kills the op without a clock edge
    op_class = 2'b10; alu_op = 4'd7; use_imm = 1'b1; in_valid = 1'b1;
    push(4'd7, 1'b1);
    step();
    in_valid = 1'b0;
    step();
    chk("kill_pre_busy", int'(busy), 1);
    chk("kill_pre_aluControl", int'(aluControl), 7);
    rst = 1'b0;
    #1;
    chk("kill_in_ready", int'(in_ready), 1);
    chk("kill_busy", int'(busy), 0);
    chk("kill_aluControl", int'(aluControl), 0);
    chk("kill_muxSel", int'(muxSel), 0);
    chk("kill_regEn", int'(regEn), 0);
    chk("kill_flush", int'(flush), 0);
    chk("kill_stall_cnt", int'(stall_cnt), 0);
    sb_q.delete();
    @(negedge clk);
    rst = 1'b1;
    op_class = 2'b00; alu_op = 4'd4; use_imm = 1'b0; in_valid = 1'b1;
    push(4'd4, 1'b0);
    step();
    in_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_regEn", int'(regEn), 1);
    chk("post_rst_aluControl", int'(aluControl), 4);
    s0 = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      s0 += int'(regEn);
    end
    chk("post_rst_no_extra_regEn", s0, 0);
    chk("sb_drained", sb_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
